mux_scan_sequencer: RTL and testbench

- Upstream/downstream companion to the 7-to-1 switch multiplexer.
- Drives the mux select lines through channels 0..6 at a programmable dwell rate.
- Samples the mux's 1-bit output at the end of each dwell.
- Assembles the 7 samples into a parallel word for LEDR/HEX display logic, with one-shot or continuous scanning.

---
 rtl/mux_scan_sequencer.sv | 148 ++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
//
// Scans an external 7-to-1 multiplexer. The select lines step through channels
// 0..6, and each channel is held for DIV clock cycles. The mux output is
// sampled at the end of each dwell. When all seven samples are taken they are
// published together as a parallel word for the LEDR/HEX display logic. A scan
// runs once per start request, or repeats while 'continuous' is high.
//
// Parameters
//   DIV : clock cycles per channel dwell (>= 1). Use 50_000_000 for the board.
//   CW  : dwell counter width. It must satisfy 2**CW > DIV-1.
//
// Ports
//   clock       in   system clock (CLOCK_50 on the board)
//   resetn      in   asynchronous active-low reset
//   start       in   level-sampled scan request. It is honoured only in IDLE.
//   continuous  in   restart the scan automatically after each DONE
//   mux_in      in   1-bit output of the 7-to-1 mux
//   select      out  [2:0] mux select. It is always in the range 0..6.
//   sample_word out  [6:0] last completed scan. Bit k = sample of channel k.
//   busy        out  high in SCAN and DONE
//   done        out  one-cycle pulse per completed scan
// -----------------------------------------------------------------------------
module mux_scan_sequencer #(
    parameter int DIV = 4,
    parameter int CW  = 26
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       continuous,
    input  logic       mux_in,
    output logic [2:0] select,
    output logic [6:0] sample_word,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [2:0]    LAST_CH  = 3'd6;

    state_t        state_reg,  state_next;
    logic [2:0]    select_reg, select_next;
    logic [CW-1:0] divcnt_reg, divcnt_next;
    // Channels 0..5 are collected here. Channel 6 goes straight into
    // sample_word on the final edge, so the published word is never partial.
    logic [5:0]    shadow_reg, shadow_next;
    logic [6:0]    word_reg,   word_next;

    logic          capture_ch;
    logic          shadow_clear;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= ST_IDLE;
            select_reg <= 3'd0;
            divcnt_reg <= '0;
            shadow_reg <= '0;
            word_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            select_reg <= select_next;
            divcnt_reg <= divcnt_next;
            shadow_reg <= shadow_next;
            word_reg   <= word_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        select_next  = select_reg;
        divcnt_next  = divcnt_reg;
        word_next    = word_reg;
        capture_ch   = 1'b0;
        shadow_clear = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                select_next = 3'd0;
                if (start) begin
                    state_next   = ST_SCAN;
                    divcnt_next  = DIV_LOAD;
                    shadow_clear = 1'b1;
                end
            end

            ST_SCAN: begin
                if (divcnt_reg != '0) begin
                    divcnt_next = divcnt_reg - CNT_ONE;
                end else if (select_reg != LAST_CH) begin
                    capture_ch  = 1'b1;
                    select_next = select_reg + 3'd1;
                    divcnt_next = DIV_LOAD;
                end else begin
                    // Final dwell: publish all seven samples on one edge.
                    // select stays on channel 6 through DONE.
                    word_next  = {mux_in, shadow_reg};
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                // continuous is sampled only here. Dropping it mid-scan lets
                // the current scan finish.
                select_next = 3'd0;
                if (continuous) begin
                    state_next   = ST_SCAN;
                    divcnt_next  = DIV_LOAD;
                    shadow_clear = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next  = ST_IDLE;
                select_next = 3'd0;
            end
        endcase
    end

    // Per-channel shadow bits. Each bit loads only while its own channel
    // is selected at the end of a dwell.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_shadow
            assign shadow_next[gi] = shadow_clear ? 1'b0 :
                                     (capture_ch && (select_reg == 3'(gi))) ? mux_in :
                                     shadow_reg[gi];
        end
    endgenerate

    // All outputs are driven from registers only.
    assign select      = select_reg;
    assign sample_word = word_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign done        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for mux_scan_sequencer.
// u_dut_a (DIV=4) is checked every cycle against a timeline model, plus
// directed literal checks. u_dut_b (DIV=1) gets directed checks only.
// Each instance has its own 7-to-1 mux model.
// -----------------------------------------------------------------------------
module tb_mux_scan_sequencer;

    localparam int DIV_A = 4;
    localparam int SCAN_LEN = 7 * DIV_A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A (DIV=4) ----------------
    logic       resetn, start, continuous, mux_in;
    logic [6:0] mux_data;
    logic [2:0] select;
    logic [6:0] sample_word;
    logic       busy, done;

    assign mux_in = mux_data[select];

    mux_scan_sequencer #(.DIV(DIV_A), .CW(26)) u_dut_a (
        .clock      (clk),
        .resetn     (resetn),
        .start      (start),
        .continuous (continuous),
        .mux_in     (mux_in),
        .select     (select),
        .sample_word(sample_word),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- DUT B (DIV=1) ----------------
    logic       resetn_b, start_b, cont_b, mux_in_b;
    logic [6:0] data_b;
    logic [2:0] select_b;
    logic [6:0] sample_word_b;
    logic       busy_b, done_b;

    assign mux_in_b = data_b[select_b];

    mux_scan_sequencer #(.DIV(1), .CW(26)) u_dut_b (
        .clock      (clk),
        .resetn     (resetn_b),
        .start      (start_b),
        .continuous (cont_b),
        .mux_in     (mux_in_b),
        .select     (select_b),
        .sample_word(sample_word_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- Timeline model for DUT A ----------------
    // A scan is a timeline of edges t = 0 .. 7*DIV measured from its launch
    // edge. Channel k is captured at t = DIV*(k+1). t = 7*DIV is the done
    // cycle. The edge after that either relaunches (t = 0) or goes idle.
    logic       m_active;
    int         m_t;
    logic [6:0] m_cap;
    logic [6:0] m_word;

    always @(posedge clk or negedge resetn) begin
        int         tn;
        int         k;
        logic [6:0] cap_next;
        if (!resetn) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_cap    <= '0;
            m_word   <= '0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_cap    <= '0;
            end
        end else begin
            tn = m_t + 1;
            if (tn <= SCAN_LEN && (tn % DIV_A) == 0) begin
                k = tn / DIV_A - 1;
                cap_next = m_cap;
                cap_next[k] = mux_data[k];
                m_cap <= cap_next;
                if (tn == SCAN_LEN) m_word <= cap_next;
            end
            if (tn == SCAN_LEN + 1) begin
                if (continuous) begin
                    m_t   <= 0;
                    m_cap <= '0;
                end else begin
                    m_active <= 1'b0;
                    m_t      <= 0;
                end
            end else begin
                m_t <= tn;
            end
        end
    end

    // Per-cycle compare of DUT A against the model
    always @(negedge clk) begin
        int es;
        if (resetn === 1'b1) begin
            es = !m_active ? 0 : ((m_t >= SCAN_LEN) ? 6 : m_t / DIV_A);
            check("model_select", int'(select), es);
            check("model_busy", int'(busy), int'(m_active));
            check("model_done", int'(done), int'(m_active && m_t == SCAN_LEN));
            check("model_word", int'(sample_word), int'(m_word));
        end
    end

    // Done-pulse logs
    int done_q[$];
    int done_b_q[$];
    int visit_b[8];

    always @(negedge clk) begin
        if (resetn === 1'b1 && done === 1'b1) done_q.push_back(cyc);
        if (resetn_b === 1'b1 && done_b === 1'b1) done_b_q.push_back(cyc);
        if (resetn_b === 1'b1 && busy_b === 1'b1 && done_b === 1'b0) visit_b[select_b]++;
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int e0;
    int n;

    initial begin
        resetn = 1'b0; start = 1'b0; continuous = 1'b0; mux_data = 7'b1010011;
        resetn_b = 1'b0; start_b = 1'b0; cont_b = 1'b0; data_b = 7'b1111111;
        for (int i = 0; i < 8; i++) visit_b[i] = 0;

        repeat (3) @(negedge clk);
        check("rst_select", int'(select), 0);
        check("rst_word", int'(sample_word), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // ---- Single scan with an ignored start at E0+10 ----
        done_q.delete();
        e0 = cyc + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(e0 + 3);
        check("single_sel_e3", int'(select), 0);
        wait_until(e0 + 4);
        check("single_sel_e4", int'(select), 1);
        wait_until(e0 + 9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(e0 + 27);
        check("single_done_e27", int'(done), 0);
        wait_until(e0 + 28);
        check("single_done_e28", int'(done), 1);
        check("single_word", int'(sample_word), int'(7'b1010011));
        wait_until(e0 + 29);
        check("single_done_e29", int'(done), 0);
        check("single_busy_after", int'(busy), 0);
        check("single_sel_after", int'(select), 0);
        wait_until(e0 + 40);
        check("single_done_count", done_q.size(), 1);
        if (done_q.size() >= 1) check("single_done_cycle", done_q[0] - e0, 28);

        // ---- Asynchronous reset mid-scan ----
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (select !== 3'd3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("midscan_reached_ch3", int'(select), 3);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_select", int'(select), 0);
        check("async_rst_word", int'(sample_word), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_select", int'(select), 0);

        // ---- Continuous, data change, continuous dropped in scan 2 ----
        done_q.delete();
        continuous = 1'b1;
        e0 = cyc + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(e0 + 28);
        check("cont_word1", int'(sample_word), int'(7'b1010011));
        wait_until(e0 + 29);
        mux_data = 7'b0101100;
        check("cont_busy_rescan", int'(busy), 1);
        wait_until(e0 + 38);
        check("cont_drop_at_ch2", int'(select), 2);
        continuous = 1'b0;
        wait_until(e0 + 57);
        check("cont_done2", int'(done), 1);
        check("cont_word2", int'(sample_word), int'(7'b0101100));
        wait_until(e0 + 100);
        check("cont_done_count", done_q.size(), 2);
        if (done_q.size() >= 2) check("cont_done_spacing", done_q[1] - done_q[0], 29);
        check("cont_busy_end", int'(busy), 0);

        // ---- start held high with continuous=0 ----
        done_q.delete();
        mux_data = 7'b1010011;
        e0 = cyc + 1;
        start = 1'b1;
        wait_until(e0 + 65);
        start = 1'b0;
        wait_until(e0 + 95);
        check("held_done_count", done_q.size(), 3);
        if (done_q.size() >= 3) begin
            check("held_first_done", done_q[0] - e0, 28);
            check("held_spacing1", done_q[1] - done_q[0], 30);
            check("held_spacing2", done_q[2] - done_q[1], 30);
        end
        check("held_word", int'(sample_word), int'(7'b1010011));

        // ---- DIV=1 instance ----
        resetn_b = 1'b1;
        repeat (2) @(negedge clk);
        check("b_idle_busy", int'(busy_b), 0);
        e0 = cyc + 1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_until(e0 + 12);
        check("b_done_count", done_b_q.size(), 1);
        if (done_b_q.size() >= 1) check("b_done_cycle", done_b_q[0] - e0, 7);
        check("b_word", int'(sample_word_b), int'(7'b1111111));
        check("b_busy_end", int'(busy_b), 0);
        for (int i = 0; i < 7; i++) check($sformatf("b_visit_ch%0d", i), visit_b[i], 1);
        check("b_visit_7", visit_b[7], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
